// File: rtl/bnn_feed_pkg.sv
// Shared types and constants for the BNN feature feeder.
package bnn_feed_pkg;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    SETTLE = 2'd1,
    OUT    = 2'd2
  } feed_state_t;

  localparam int SETTLE_CNT_BITS = 4;

  // Index width for a feature count, kept at least one bit wide.
  function automatic int idx_bits(input int feat_cnt);
    return (feat_cnt > 1) ? $clog2(feat_cnt) : 1;
  endfunction

endpackage

// File: rtl/bnn_feed_settle_timer.sv
// Loadable down-counter with a zero flag; times the bus settle window.
module bnn_feed_settle_timer
  import bnn_feed_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load,
  input  logic [SETTLE_CNT_BITS-1:0] load_val,
  input  logic                       dec,
  output logic                       is_zero
);

  logic [SETTLE_CNT_BITS-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - SETTLE_CNT_BITS'(1);
    end
  end

  assign is_zero = (count == '0);

endmodule

// File: rtl/bnn_feature_feeder.sv
// Packs feature samples onto the classifier bus, waits out the settle window and
// returns the class; BNN_FEED_LAST_CHECK_EN adds in_last framing checks with sticky err.
module bnn_feature_feeder
  import bnn_feed_pkg::*;
#(
  parameter int FEAT_CNT      = 11,
  parameter int FEAT_BITS     = 4,
  parameter int CLASS_CNT     = 6,
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_BITS      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [FEAT_BITS-1:0]          in_feat,
  input  logic                          in_last,
  output logic [FEAT_CNT*FEAT_BITS-1:0] features,
  input  logic [$clog2(CLASS_CNT)-1:0]  prediction,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(CLASS_CNT)-1:0]  out_class,
  output logic [CNT_BITS-1:0]           out_count,
  output logic                          err
);

  localparam int IDX_BITS = idx_bits(FEAT_CNT);
  localparam int CLS_BITS = $clog2(CLASS_CNT);
  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(FEAT_CNT - 1);

  feed_state_t                   state;
  logic [IDX_BITS-1:0]           idx;
  logic [FEAT_CNT*FEAT_BITS-1:0] feat_reg;
  logic                          out_valid_r;
  logic [CLS_BITS-1:0]           class_r;
  logic [CNT_BITS-1:0]           count_r;
  logic                          accept;
  logic                          early_end;
  logic                          close_vec;
  logic                          timer_zero;

  assign in_ready = (state == LOAD);
  assign accept   = in_valid && in_ready;

`ifdef BNN_FEED_LAST_CHECK_EN
  logic err_r;
  logic err_set;

  assign early_end = in_last && (idx != LAST_IDX);
  assign err_set   = accept && (early_end || (!in_last && (idx == LAST_IDX)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_r <= 1'b0;
    end else if (err_set) begin
      err_r <= 1'b1;
    end
  end

  assign err = err_r;
`else
  logic unused_last;

  assign unused_last = in_last;
  assign early_end   = 1'b0;
  assign err         = 1'b0;
`endif

  assign close_vec = accept && ((idx == LAST_IDX) || early_end);

  bnn_feed_settle_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (close_vec),
    .load_val (SETTLE_CNT_BITS'(SETTLE_CYCLES)),
    .dec      ((state == SETTLE) && !timer_zero),
    .is_zero  (timer_zero)
  );

  // An early end also blanks the tail so stale features never reach the classifier.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      feat_reg <= '0;
    end else if (accept) begin
      for (int k = 0; k < FEAT_CNT; k++) begin
        if (IDX_BITS'(k) == idx) begin
          feat_reg[k*FEAT_BITS +: FEAT_BITS] <= in_feat;
        end else if (early_end && (IDX_BITS'(k) > idx)) begin
          feat_reg[k*FEAT_BITS +: FEAT_BITS] <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= LOAD;
      idx         <= '0;
      out_valid_r <= 1'b0;
      class_r     <= '0;
      count_r     <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (accept) begin
            if (close_vec) begin
              idx   <= '0;
              state <= SETTLE;
            end else begin
              idx <= idx + IDX_BITS'(1);
            end
          end
        end
        SETTLE: begin
          if (timer_zero) begin
            class_r     <= prediction;
            out_valid_r <= 1'b1;
            state       <= OUT;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            count_r     <= count_r + CNT_BITS'(1);
            state       <= LOAD;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  assign features  = feat_reg;
  assign out_valid = out_valid_r;
  assign out_class = class_r;
  assign out_count = count_r;

endmodule

// File: tb/tb_bnn_feature_feeder.sv
// Scoreboard bench for bnn_feature_feeder: random vectors, a stub classifier and a
// second instance with SETTLE_CYCLES=0 / CNT_BITS=2 for latency and counter wrap.
module tb_bnn_feature_feeder;

  localparam int FC = 11;
  localparam int FB = 4;
  localparam int CC = 6;
  localparam int S  = 2;

  typedef struct {
    logic [63:0] bus;
    logic [2:0]  cls;
    int          acc_cyc;
    logic        err;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid, in_ready, in_last;
  logic [FB-1:0]  in_feat;
  logic [FC*FB-1:0] features;
  logic [2:0]     prediction, out_class, junk;
  logic           out_valid, out_ready, err;
  logic [15:0]    out_count;

  logic           in_valid_b, in_ready_b, in_last_b;
  logic [FB-1:0]  in_feat_b;
  logic [FC*FB-1:0] features_b;
  logic [2:0]     prediction_b, out_class_b;
  logic           out_valid_b, out_ready_b, err_b;
  logic [1:0]     out_count_b;

  exp_t           exp_q[$];
  exp_t           mon_e;
  logic [3:0]     vals [FC];
  int             n_cmp = 0;
  int             n_bad = 0;
  int             cyc = 0;
  int             model_count = 0;
  logic           err_model = 1'b0;
  int             ready_mode = 2;
  logic           prev_valid = 1'b0;
  logic           cnt_pending = 1'b0;
  logic [2:0]     held_class = '0;

  bnn_feature_feeder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_feat(in_feat),
    .in_last(in_last), .features(features), .prediction(prediction), .out_valid(out_valid),
    .out_ready(out_ready), .out_class(out_class), .out_count(out_count), .err(err)
  );

  bnn_feature_feeder #(.SETTLE_CYCLES(0), .CNT_BITS(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b), .in_feat(in_feat_b),
    .in_last(in_last_b), .features(features_b), .prediction(prediction_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_class(out_class_b),
    .out_count(out_count_b), .err(err_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(posedge clk) junk <= 3'($urandom_range(0, CC - 1));

  // Stub classifier: class is (sum of features + 4) mod CC; junk while a result is shown.
  function automatic logic [2:0] stub_class(input logic [FC*FB-1:0] bus);
    int s;
    s = 0;
    for (int k = 0; k < FC; k++) s += int'(bus[k*FB +: FB]);
    return 3'((s + 4) % CC);
  endfunction

  assign prediction   = out_valid ? junk : stub_class(features);
  assign prediction_b = stub_class(features_b);

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = ($urandom_range(0, 3) != 0);
      1:       out_ready = 1'b0;
      default: out_ready = 1'b1;
    endcase
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeoutFail(input string name);
    n_cmp++;
    n_bad++;
    $display("[TB] FAIL %s: timed out waiting on DUT", name);
  endtask

  task automatic sendOne(input logic [3:0] v, input logic lst, output int acc);
    logic rdy;
    int   waited;
    waited = 0;
    acc = 0;
    in_valid = 1'b1;
    in_feat  = v;
    in_last  = lst;
    forever begin
      rdy = in_ready;
      @(posedge clk); #1;
      if (rdy) break;
      waited++;
      if (waited > 200) begin
        timeoutFail("accept");
        break;
      end
    end
    acc = cyc;
    in_valid = 1'b0;
  endtask

  task automatic sendOneB(input logic [3:0] v, input logic lst);
    logic rdy;
    int   waited;
    waited = 0;
    in_valid_b = 1'b1;
    in_feat_b  = v;
    in_last_b  = lst;
    forever begin
      rdy = in_ready_b;
      @(posedge clk); #1;
      if (rdy) break;
      waited++;
      if (waited > 200) begin
        timeoutFail("accept_b");
        break;
      end
    end
    in_valid_b = 1'b0;
  endtask

  // last_pos: index carrying in_last (FC-1 normal, smaller = early end, -1 = missing end).
  task automatic applyStimulus(input int last_pos, input bit gaps);
    int   n, acc, s;
    bit   early;
    logic lst;
    exp_t e;
    early = 1'b0;
`ifdef BNN_FEED_LAST_CHECK_EN
    early = (last_pos >= 0) && (last_pos < FC - 1);
    if (last_pos != FC - 1) err_model = 1'b1;
`endif
    n = early ? last_pos + 1 : FC;
    e.bus = '0;
    s = 0;
    acc = 0;
    for (int i = 0; i < n; i++) begin
`ifdef BNN_FEED_LAST_CHECK_EN
      lst = (i == last_pos);
`else
      lst = 1'($urandom_range(0, 1));
`endif
      sendOne(vals[i], lst, acc);
      e.bus |= 64'(vals[i]) << (FB * i);
      s += int'(vals[i]);
      if (gaps && (i < n - 1)) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    end
    e.cls = 3'((s + 4) % CC);
    e.acc_cyc = acc;
    e.err = err_model;
    exp_q.push_back(e);
  endtask

  task automatic randomVals();
    for (int i = 0; i < FC; i++) vals[i] = 4'($urandom_range(0, 15));
  endtask

  task automatic waitIdle();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || out_valid) && t < 500) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 500) timeoutFail("idle");
  endtask

  // Monitor: compares each presented result against the scoreboard head.
  always @(negedge clk) begin
    if (rst) begin
      prev_valid  = 1'b0;
      cnt_pending = 1'b0;
    end else begin
      if (cnt_pending) begin
        checkOutput("out_count", 64'(out_count), 64'(model_count % 65536));
        checkOutput("valid_drop", 64'(out_valid), 64'd0);
        cnt_pending = 1'b0;
      end
      if (out_valid) begin
        checkOutput("in_ready_blocked", 64'(in_ready), 64'd0);
        if (!prev_valid) begin
          if (exp_q.size() == 0) begin
            timeoutFail("unexpected_result");
          end else begin
            mon_e = exp_q.pop_front();
            checkOutput("out_class", 64'(out_class), 64'(mon_e.cls));
            checkOutput("features", 64'(features), mon_e.bus);
            checkOutput("latency", 64'(cyc - mon_e.acc_cyc), 64'(S + 1));
            checkOutput("err", 64'(err), 64'(mon_e.err));
          end
          held_class = out_class;
        end else begin
          checkOutput("class_hold", 64'(out_class), 64'(held_class));
        end
        if (out_ready) begin
          model_count++;
          cnt_pending = 1'b1;
        end
      end
      prev_valid = out_valid;
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          acc, s, t;
    logic [63:0] bus_b;
    logic [3:0]  f;
    rst = 1'b1;
    in_valid = 1'b0; in_feat = '0; in_last = 1'b0;
    in_valid_b = 1'b0; in_feat_b = '0; in_last_b = 1'b0; out_ready_b = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_features", 64'(features), 64'd0);
    checkOutput("rst_out_count", 64'(out_count), 64'd0);
    checkOutput("rst_err", 64'(err), 64'd0);

    $display("[TB] basic vector 1..11");
    for (int i = 0; i < FC; i++) vals[i] = 4'(i + 1);
    applyStimulus(FC - 1, 1'b0);
    waitIdle();

    $display("[TB] backpressure");
    ready_mode = 1;
    randomVals();
    applyStimulus(FC - 1, 1'b0);
    t = 0;
    while (!out_valid && t < 100) begin @(posedge clk); #1; t++; end
    if (t >= 100) timeoutFail("bp_valid");
    repeat (10) begin @(posedge clk); #1; end
    checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
    checkOutput("bp_valid_held", 64'(out_valid), 64'd1);
    ready_mode = 2;
    waitIdle();

    $display("[TB] random vectors with gaps");
    ready_mode = 0;
    for (int v = 0; v < 20; v++) begin
      randomVals();
      applyStimulus(FC - 1, 1'b1);
    end
    ready_mode = 2;
    waitIdle();

`ifdef BNN_FEED_LAST_CHECK_EN
    $display("[TB] framing errors");
    randomVals();
    applyStimulus(4, 1'b0);
    waitIdle();
    randomVals();
    applyStimulus(-1, 1'b0);
    waitIdle();
    randomVals();
    applyStimulus(FC - 1, 1'b0);
    waitIdle();
`endif

    $display("[TB] reset mid-vector");
    randomVals();
    for (int i = 0; i < 6; i++) sendOne(vals[i], 1'b0, acc);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_features", 64'(features), 64'd0);
    checkOutput("mid_rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("mid_rst_out_class", 64'(out_class), 64'd0);
    checkOutput("mid_rst_out_count", 64'(out_count), 64'd0);
    checkOutput("mid_rst_err", 64'(err), 64'd0);
    exp_q.delete();
    model_count = 0;
    err_model = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("post_rst_in_ready", 64'(in_ready), 64'd1);
    randomVals();
    applyStimulus(FC - 1, 1'b0);
    waitIdle();

    $display("[TB] SETTLE_CYCLES=0 and CNT_BITS=2 wrap");
    for (int v = 0; v < 5; v++) begin
      bus_b = '0;
      s = 0;
      for (int i = 0; i < FC; i++) begin
        f = 4'($urandom_range(0, 15));
        sendOneB(f, i == FC - 1);
        bus_b |= 64'(f) << (FB * i);
        s += int'(f);
      end
      checkOutput("b_valid_at_accept", 64'(out_valid_b), 64'd0);
      @(posedge clk); #1;
      checkOutput("b_valid_after_1", 64'(out_valid_b), 64'd1);
      checkOutput("b_class", 64'(out_class_b), 64'((s + 4) % CC));
      checkOutput("b_features", 64'(features_b), bus_b);
      out_ready_b = 1'b1;
      @(posedge clk); #1;
      out_ready_b = 1'b0;
      checkOutput("b_count", 64'(out_count_b), 64'((v + 1) % 4));
    end
    checkOutput("b_err", 64'(err_b), 64'd0);

    checkOutput("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bnn_feature_feeder.md
# bnn_feature_feeder

Sequential front end for the combinational BNN classifiers (`<dataset>_bnn1_bnnpaarter`). It accepts quantized feature samples one per handshake and packs them into the classifier's `features` bus. It holds the bus stable for a fixed settle window, then samples `prediction` and returns the class on a valid/ready output channel. It drives the classifier's input and consumes its output, so hardware test streams can run back-to-back without a testbench driving the bus directly.

## Interface
Parameters:
- `FEAT_CNT`, 11: features per vector.
- `FEAT_BITS`, 4: bits per feature.
- `CLASS_CNT`, 6: classifier class count.
- `SETTLE_CYCLES`, 2: extra cycles the bus is held after the last feature load before `prediction` is sampled. Range 0..15.
- `CNT_BITS`, 16: width of the classified-vector counter.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  clock, all state on rising edge.
- `rst`  in  1  asynchronous active-high reset.
- `in_valid`  in  1  feature sample valid.
- `in_ready`  out  1  feeder accepts a sample.
- `in_feat`  in  FEAT_BITS  unsigned feature value.
- `in_last`  in  1  marks the final feature of a vector; used only under the macro.
- `features`  out  FEAT_CNT*FEAT_BITS  packed bus to the classifier; feature k sits at `[k*FEAT_BITS +: FEAT_BITS]`.
- `prediction`  in  $clog2(CLASS_CNT)  classifier result.
- `out_valid`  out  1  class result valid.
- `out_ready`  in  1  downstream accepts the result.
- `out_class`  out  $clog2(CLASS_CNT)  registered class.
- `out_count`  out  CNT_BITS  number of results delivered; wraps modulo 2^CNT_BITS.
- `err`  out  1  sticky framing error; tied 0 without the macro.

## Operation
States:
- **LOAD**
  - `in_ready`=1 only in this state.
  - On accept, write `in_feat` into slot `idx` of the `features` register, then increment `idx`.
  - On accepting slot FEAT_CNT-1: reset `idx` to 0, load the settle counter with SETTLE_CYCLES, go to SETTLE.
- **SETTLE**
  - If the counter is 0: register `prediction` into `out_class` and go to OUT.
  - Otherwise decrement the counter.
- **OUT**
  - `out_valid`=1.
  - On `out_valid && out_ready`: increment `out_count`, go to LOAD.
  - `out_class` is stable while waiting.

Data rules:
- The `features` register holds the previous vector and is overwritten slot by slot during LOAD. `prediction` is sampled only in SETTLE, so partial mixes are never reported.
- No input is accepted during SETTLE or OUT, so backpressure propagates upstream.

Reset values: state LOAD, `idx` 0, `features` 0, `out_valid` 0, `out_class` 0, `out_count` 0, `err` 0. A reset mid-vector or mid-OUT discards that vector. `in_ready` is 1 in the first cycle after reset release.

## Timing
- The last feature is accepted at edge E. `out_valid` rises after edge E+SETTLE_CYCLES+1, and `prediction` is sampled at that same edge. The classifier therefore gets SETTLE_CYCLES+1 full cycles of a stable bus.
- The output handshake completes at edge H. `in_ready` is 1 in the cycle after H.
- Throughput is one vector per FEAT_CNT+SETTLE_CYCLES+2 cycles with no stalls. Defaults: 15 cycles.
- `out_count` updates at the same edge as the output handshake. Past 2^CNT_BITS−1 it wraps to 0.

## Configuration
`BNN_FEED_LAST_CHECK_EN` enables the framing check.

With the macro defined:
- `in_last` is checked on every accept.
- `in_last`=1 at `idx` < FEAT_CNT-1 (early end):
  - Slots `idx`+1..FEAT_CNT-1 are cleared to 0 at the same edge, and the vector proceeds to SETTLE.
  - `err` is set.
- `in_last`=0 at `idx` = FEAT_CNT-1 (missing end): the vector closes normally and `err` is set.
- `err` is sticky until `rst`.

Without the macro: `in_last` is ignored, `err`=0, and no check logic is built.

## Structure
- Package `bnn_feed_pkg` holds:
  - the state enum (LOAD, SETTLE, OUT);
  - the `IDX_BITS` = $clog2(FEAT_CNT) helper;
  - the settle-counter width constant.
- One sub-module, `bnn_feed_settle_timer`: a loadable down-counter with a zero flag, used by SETTLE.
- The classifier is instantiated by the parent, not inside this block.

## Test plan
- **Basic vector:** defaults, feed features 1..11 with `in_valid` held high.
  - `features` = 0xBA987654321 after the 11th accept.
  - `out_valid` rises exactly 3 cycles later.
  - `out_class` equals the `prediction` stub value 4, and `out_count` = 1.
- **Backpressure:** hold `out_ready`=0 for 10 cycles while changing `prediction`.
  - `out_class` holds the sampled value.
  - `in_ready` stays 0.
  - A single handshake occurs on release.
- **Input gaps:** random `in_valid` gaps during LOAD.
  - Slot order is unchanged.
  - Latency from the last accept is still SETTLE_CYCLES+1.
- **SETTLE_CYCLES=0:** `out_valid` follows one cycle after the last accept.
- **Framing errors (macro on):**
  - `in_last` at feature 5: slots 5..10 read 0 and `err`=1.
  - Next vector with a missing `in_last`: it closes at 11 features and `err` stays 1.
- **Reset and wrap:**
  - Assert `rst` mid-vector at `idx`=6: all outputs return to reset values, and the next vector loads from slot 0.
  - With CNT_BITS=2, deliver 5 results: `out_count` = 1.
